// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared constants, state encoding and width helper for the CAM match reader
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    READ = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } cam_state_t;

  // floor(log2(value))+1, so a count of exactly `value` still fits
  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// rtl/cam_prio_enc.sv - combinational lowest-set-bit encoder over the CAM tag vector
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int  CELL_QUANT = 512,
  localparam int ADDR_BITS  = clogb2(CELL_QUANT)
) (
  input  logic [CELL_QUANT-1:0] vec,
  output logic [ADDR_BITS-1:0]  idx,
  output logic                  found
);

  // Scan downwards so the last hit written is the lowest index
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = CELL_QUANT - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = ADDR_BITS'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_match_reader.sv
// rtl/cam_match_reader.sv - drains CAM match tags into an {address, word} stream; CAM_READER_ABORT_EN adds an abort input
module cam_match_reader
  import cam_pkg::*;
#(
  parameter int  WORD_SIZE  = 8,
  parameter int  CELL_QUANT = 512,
  localparam int ADDR_BITS  = clogb2(CELL_QUANT)
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst_n,
  input  logic                  start,
`ifdef CAM_READER_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [CELL_QUANT-1:0] tags,
  input  logic [WORD_SIZE-1:0]  cam_doutb,
  output logic [ADDR_BITS-1:0]  cam_addr,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_SIZE-1:0]  m_data,
  output logic [ADDR_BITS-1:0]  m_addr,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_BITS-1:0]  match_count
);

  cam_state_t            state_q;
  cam_state_t            state_d;
  logic [CELL_QUANT-1:0] pending;
  logic [ADDR_BITS-1:0]  enc_idx;
  logic                  enc_found;
  logic                  abort_hit;

  cam_prio_enc #(
    .CELL_QUANT(CELL_QUANT)
  ) u_prio_enc (
    .vec  (pending),
    .idx  (enc_idx),
    .found(enc_found)
  );

`ifdef CAM_READER_ABORT_EN
  assign abort_hit = abort && (state_q == SCAN || state_q == READ || state_q == OUT);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    state_d = enc_found ? READ : DONE;
      READ:    state_d = OUT;
      OUT:     if (m_ready) state_d = m_last ? DONE : SCAN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = DONE;
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      cam_addr    <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_addr      <= '0;
      m_last      <= 1'b0;
      match_count <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pending     <= tags;
            match_count <= '0;
          end
        end
        SCAN: begin
          // x & (x-1) drops exactly the bit the encoder picked
          if (enc_found) begin
            cam_addr <= enc_idx;
            pending  <= pending & (pending - CELL_QUANT'(1));
          end
        end
        READ: begin
          m_data  <= cam_doutb;
          m_addr  <= cam_addr;
          m_last  <= (pending == '0);
          m_valid <= 1'b1;
        end
        OUT: begin
          if (m_ready && !abort_hit) begin
            m_valid     <= 1'b0;
            match_count <= match_count + ADDR_BITS'(1);
          end
        end
        default: ;
      endcase
      if (abort_hit) begin
        pending <= '0;
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cam_match_reader.sv
// tb/tb_cam_match_reader.sv - directed table-driven bench for cam_match_reader with an 8-cell CAM model
module tb_cam_match_reader;

  localparam int WS = 8;
  localparam int CQ = 8;
  localparam int AB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CQ-1:0] tags;
  logic [WS-1:0] cam_doutb;
  logic [AB-1:0] cam_addr;
  logic          m_valid;
  logic          m_ready;
  logic [WS-1:0] m_data;
  logic [AB-1:0] m_addr;
  logic          m_last;
  logic          busy;
  logic          done;
  logic [AB-1:0] match_count;
`ifdef CAM_READER_ABORT_EN
  logic          abort;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // CAM cell i holds 0xA0+i
  assign cam_doutb = 8'hA0 + {4'b0000, cam_addr};

  cam_match_reader #(
    .WORD_SIZE (WS),
    .CELL_QUANT(CQ)
  ) dut (
    .CLK100MHZ  (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef CAM_READER_ABORT_EN
    .abort      (abort),
`endif
    .tags       (tags),
    .cam_doutb  (cam_doutb),
    .cam_addr   (cam_addr),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_addr     (m_addr),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done),
    .match_count(match_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] tags;
    int         stall;
    bit         disturb;
    int         exp_cnt;
  } vec_t;

  task automatic run_scan(input vec_t v);
    int         exp_addr[$];
    int         hs_cyc[$];
    int         cyc;
    int         k;
    int         stall_n;
    int         done_cyc;
    int         first_valid;
    bit         seen_done;
    logic       prev_v;
    logic       prev_r;
    logic [7:0] hold_d;
    logic [3:0] hold_a;
    logic       hold_l;
    for (int i = 0; i < CQ; i++) if (v.tags[i]) exp_addr.push_back(i);
    @(negedge clk);
    tags    = v.tags;
    start   = 1'b1;
    m_ready = 1'b0;
    cyc = 0; k = 0; stall_n = 0; done_cyc = 0; first_valid = -1;
    seen_done = 0; prev_v = 1'b0; prev_r = 1'b0;
    hold_d = '0; hold_a = '0; hold_l = 1'b0;
    while (cyc < 200 && !seen_done) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (v.disturb && cyc == 4) begin
        tags  = '0;
        start = 1'b1;
      end
      if (prev_v && !prev_r) begin
        chk("hold_valid", m_valid, 1'b1);
        chk("hold_data", m_data, hold_d);
        chk("hold_addr", m_addr, hold_a);
        chk("hold_last", m_last, hold_l);
      end
      if (m_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (!prev_v) begin
          hold_d = m_data; hold_a = m_addr; hold_l = m_last;
        end
        if (stall_n < v.stall) begin
          stall_n++;
          m_ready = 1'b0;
        end else begin
          m_ready = 1'b1;
          if (k < exp_addr.size()) begin
            chk("word_addr", m_addr, exp_addr[k]);
            chk("word_data", m_data, 8'hA0 + exp_addr[k]);
            chk("word_last", m_last, (k == exp_addr.size() - 1));
          end else begin
            chk("extra_word", k, exp_addr.size());
          end
          hs_cyc.push_back(cyc);
          k++;
          stall_n = 0;
        end
      end else begin
        m_ready = 1'b0;
      end
      prev_v = m_valid;
      prev_r = m_ready;
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
        chk("busy_at_done", busy, 1'b1);
      end
    end
    chk("done_seen", seen_done, 1'b1);
    chk("word_count", k, v.exp_cnt);
    chk("match_count", match_count, v.exp_cnt);
    if (v.exp_cnt == 0) begin
      chk("empty_done_latency", done_cyc, 2);
      chk("empty_no_valid", first_valid, -1);
    end else begin
      chk("first_valid_cycle", first_valid, 3);
      if (v.stall == 0)
        for (int i = 1; i < hs_cyc.size(); i++)
          chk("word_period", hs_cyc[i] - hs_cyc[i-1], 3);
      if (hs_cyc.size() > 0) chk("done_after_last_hs", done_cyc - hs_cyc[hs_cyc.size()-1], 1);
    end
    @(negedge clk);
    m_ready = 1'b0;
    chk("done_one_cycle", done, 1'b0);
    chk("idle_not_busy", busy, 1'b0);
    chk("count_holds", match_count, v.exp_cnt);
    tags = '0;
  endtask

  vec_t vecs[5];

  initial begin
    int vcnt;
    int w;
    vecs[0] = '{tags: 8'b0010_0101, stall: 0, disturb: 1'b0, exp_cnt: 3};
    vecs[1] = '{tags: 8'h00,        stall: 0, disturb: 1'b0, exp_cnt: 0};
    vecs[2] = '{tags: 8'h80,        stall: 5, disturb: 1'b0, exp_cnt: 1};
    vecs[3] = '{tags: 8'hFF,        stall: 0, disturb: 1'b1, exp_cnt: 8};
    vecs[4] = '{tags: 8'h81,        stall: 2, disturb: 1'b0, exp_cnt: 2};

    rst_n = 1'b0; start = 1'b0; tags = '0; m_ready = 1'b0;
`ifdef CAM_READER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_cam_addr", cam_addr, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_match_count", match_count, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);

    for (int i = 0; i < 5; i++) run_scan(vecs[i]);

    // reset while a word is stalled in OUT
    @(negedge clk);
    tags = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", m_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", m_valid, 1'b0);
    chk("async_rst_data", m_data, 8'h00);
    chk("async_rst_addr", m_addr, 4'd0);
    chk("async_rst_last", m_last, 1'b0);
    chk("async_rst_cam_addr", cam_addr, 4'd0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_count", match_count, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tags  = '0;
    vcnt  = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || m_valid) vcnt++;
    end
    chk("no_done_after_rst", vcnt, 0);
    run_scan('{tags: 8'h02, stall: 0, disturb: 1'b0, exp_cnt: 1});

`ifdef CAM_READER_ABORT_EN
    @(negedge clk);
    tags = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0; m_ready = 1'b1;
    w = 0;
    while (!m_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("abort_first_valid", m_valid, 1'b1);
    @(negedge clk);
    abort = 1'b1; m_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done", done, 1'b1);
    chk("abort_count", match_count, 4'd1);
    chk("abort_valid", m_valid, 1'b0);
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_valid || done) vcnt++;
    end
    chk("abort_quiet", vcnt, 0);
    chk("abort_count_holds", match_count, 4'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
